// File: rtl/sram_rd_sched_if.sv
// Requester, read-return and write-channel bundle of the burst read scheduler.
// The master side drives requests and writes; the slave side is the scheduler.
interface sram_rd_sched_if #(
    parameter int unsigned WWORD = 32,
    parameter int unsigned WADDR = 5,
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WLEN  = 4
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WADDR-1:0] req_addr;
    logic [NREQ*WLEN-1:0]  req_len;
    logic [NREQ-1:0]       gnt;
    logic                  busy;
    logic                  rvalid;
    logic [2:0]            rid;
    logic                  rlast;
    logic [WWORD-1:0]      rdata;
    logic                  wr_valid;
    logic [WADDR-1:0]      wr_addr;
    logic [WWORD-1:0]      wr_data;
    logic                  wr_err;

    modport master (
        output req, req_addr, req_len, wr_valid, wr_addr, wr_data,
        input  gnt, busy, rvalid, rid, rlast, rdata, wr_err
    );

    modport slave (
        input  req, req_addr, req_len, wr_valid, wr_addr, wr_data,
        output gnt, busy, rvalid, rid, rlast, rdata, wr_err
    );
endinterface

// File: rtl/sram_rd_sched.sv
// Burst read scheduler for one dual-port SRAM: round-robin burst arbitration on
// read port A with tagged returns, plus a checked pass-through write on port B.
module sram_rd_sched #(
    parameter int unsigned WWORD = 32,
    parameter int unsigned WADDR = 5,
    parameter int unsigned DEPTH = 24,
    parameter int unsigned NREQ  = 4,
    parameter int unsigned WLEN  = 4
) (
    input  logic             clk,
    input  logic             rst,
    sram_rd_sched_if.slave   bus,
    output logic [WADDR-1:0] sram_aa,
    output logic             sram_cena,
    input  logic [WWORD-1:0] sram_qa,
    output logic [WADDR-1:0] sram_ab,
    output logic [WWORD-1:0] sram_db,
    output logic             sram_cenb
);
    typedef enum logic [0:0] {StIdle, StBurst} state_e;

    state_e           state_q, state_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [2:0]       owner_q, owner_d;
    logic [WADDR-1:0] addr_q, addr_d;
    logic [WLEN-1:0]  cnt_q, cnt_d;
    logic             rvalid_q, rvalid_d;
    logic             rlast_q, rlast_d;
    logic [2:0]       rid_q, rid_d;
    logic             wr_err_q;

    logic [7:0]       req_pad;
    logic             found;
    logic [2:0]       win;
    logic [2:0]       idx;
    logic [WADDR-1:0] sel_addr;
    logic [WLEN-1:0]  sel_len;

    assign req_pad = 8'(bus.req);

    // Round-robin search starting at the pointer, wrapping at NREQ.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = 3'((32'(ptr_q) + k) % NREQ);
            if (!found && req_pad[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_len  = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (3'(i) == win) begin
                sel_addr = bus.req_addr[i*WADDR +: WADDR];
                sel_len  = bus.req_len[i*WLEN +: WLEN];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = '0;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        rvalid_d  = 1'b0;
        rlast_d   = 1'b0;
        rid_d     = rid_q;
        sram_cena = 1'b1;
        sram_aa   = addr_q;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    state_d = StBurst;
                    for (int unsigned i = 0; i < NREQ; i++) begin
                        gnt_d[i] = (3'(i) == win);
                    end
                    ptr_d   = (win == 3'(NREQ - 1)) ? 3'd0 : win + 3'd1;
                    owner_d = win;
                    // Illegal start addresses restart the burst at word 0.
                    addr_d  = (32'(sel_addr) >= DEPTH) ? '0 : sel_addr;
                    cnt_d   = sel_len;
                end
            end
            StBurst: begin
                sram_cena = 1'b0;
                rvalid_d  = 1'b1;
                rid_d     = owner_q;
                rlast_d   = (cnt_q == '0);
                addr_d    = (32'(addr_q) == DEPTH - 1) ? '0 : addr_q + 1'b1;
                cnt_d     = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            gnt_q    <= '0;
            ptr_q    <= '0;
            owner_q  <= '0;
            addr_q   <= '0;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            rid_q    <= '0;
            wr_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            rlast_q  <= rlast_d;
            rid_q    <= rid_d;
            wr_err_q <= bus.wr_valid & (32'(bus.wr_addr) >= DEPTH);
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.busy   = (state_q == StBurst) | rvalid_q;
    assign bus.rvalid = rvalid_q;
    assign bus.rid    = rid_q;
    assign bus.rlast  = rlast_q;
    assign bus.rdata  = sram_qa;
    assign bus.wr_err = wr_err_q;

    // The SRAM itself drops out-of-range writes; wr_err only reports them.
    assign sram_cenb = ~bus.wr_valid;
    assign sram_ab   = bus.wr_addr;
    assign sram_db   = bus.wr_data;
endmodule
